// File: rtl/rx_frame_buffer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx_frame_buffer_ctrl_pkg
// Shared definitions for the HDLC receive frame buffer controller:
//   - receive sequencer states (IDLE / RECV / DROP)
//   - FCS byte count stripped from every committed frame
//   - drop-cause codes (SHORT / CRC / ABORT / OVF)
//   - frame descriptor {start, len} pushed into the descriptor FIFO
//   - saturating 8-bit increment used by the optional drop statistics
// The descriptor fields are sized from BUF_ADDR_W; the top-level ADDR_W
// parameter defaults to the same value and must track it.
// ---------------------------------------------------------------------------
package rx_frame_buffer_ctrl_pkg;

    localparam int BUF_ADDR_W = 11;
    localparam int PTR_W      = BUF_ADDR_W + 1;
    localparam int FCS_BYTES  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        SHORT = 2'd0,
        CRC   = 2'd1,
        ABORT = 2'd2,
        OVF   = 2'd3
    } drop_cause_e;

    typedef struct packed {
        logic [PTR_W-1:0] start;
        logic [PTR_W-1:0] len;
    } rx_desc_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        sat_inc8 = (value == 8'hFF) ? 8'hFF : (value + 8'd1);
    endfunction

endpackage

// File: rtl/rx_frame_buffer_ctrl_desc_fifo.sv
// ---------------------------------------------------------------------------
// rx_desc_fifo
// Synchronous descriptor FIFO between the receive sequencer and the host.
// Registered full/empty flags; push and pop in the same cycle both act.
// Ports:
//   netclk, reset_n     clock, asynchronous active-low reset
//   push, push_desc     write a descriptor (ignored when full)
//   pop                 drop the head descriptor (ignored when empty)
//   head_desc           descriptor at the head of the queue
//   full, empty         occupancy flags
// ---------------------------------------------------------------------------
module rx_desc_fifo
    import rx_frame_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic     netclk,
    input  logic     reset_n,
    input  logic     push,
    input  rx_desc_t push_desc,
    input  logic     pop,
    output rx_desc_t head_desc,
    output logic     full,
    output logic     empty
);

    localparam int DEPTH = 32'd1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = DEPTH_LOG2'(1'b1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1'b1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    rx_desc_t              slot_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_idx_r;
    logic [DEPTH_LOG2-1:0] rd_idx_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Qualify push/pop against the flags and compute the next occupancy.
    always_comb begin
        push_ok_s = push & ~full_r;
        pop_ok_s  = pop & ~empty_r;
        count_s   = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_s = count_r - CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Storage, indices and registered occupancy flags.
    always_ff @(posedge netclk or negedge reset_n) begin
        if (!reset_n) begin
            slot_r   <= '{default: '0};
            wr_idx_r <= '0;
            rd_idx_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                slot_r[wr_idx_r] <= push_desc;
                wr_idx_r         <= wr_idx_r + IDX_ONE;
            end
            if (pop_ok_s) begin
                rd_idx_r <= rd_idx_r + IDX_ONE;
            end
            count_r <= count_s;
            full_r  <= (count_s == CNT_FULL);
            empty_r <= (count_s == '0);
        end
    end

    assign head_desc = slot_r[rd_idx_r];
    assign full      = full_r;
    assign empty     = empty_r;

endmodule

// File: rtl/rx_frame_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_buffer_ctrl
// Receive frame buffer controller behind the HDLC deframer (netclk domain).
// Bytes are written speculatively into a circular byte buffer; on the closing
// flag the frame is committed with its FCS stripped, or rewound on short
// frame, CRC error, abort or overflow. Committed frames are published through
// a descriptor FIFO and a registered byte read port.
// Optional build macro: RX_FRAME_STATS_EN adds saturating drop counters.
// Ports:
//   netclk, reset_n         clock, asynchronous active-low reset
//   enable                  accept new frames
//   byte_ready, rx_byte     deframer byte strobe (level) and data
//   frame_complete          closing-flag level; frame_valid sampled on its rise
//   frame_abort             one-cycle abort pulse
//   desc_valid, desc_len    head descriptor present / payload length
//   desc_ack                release head frame
//   rd_req, rd_data, rd_valid   byte read port for the head frame
//   rx_err                  one-cycle pulse per dropped frame
//   stats_clr, *_cnt        (RX_FRAME_STATS_EN only) drop statistics
// ---------------------------------------------------------------------------
module rx_frame_buffer_ctrl
    import rx_frame_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W    = BUF_ADDR_W,
    parameter int DESC_LOG2 = 2,
    parameter int MIN_FRAME = 4
) (
    input  logic            netclk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            byte_ready,
    input  logic [7:0]      rx_byte,
    input  logic            frame_complete,
    input  logic            frame_valid,
    input  logic            frame_abort,
    output logic            desc_valid,
    output logic [ADDR_W:0] desc_len,
    input  logic            desc_ack,
    input  logic            rd_req,
    output logic [7:0]      rd_data,
    output logic            rd_valid,
    output logic            rx_err
`ifdef RX_FRAME_STATS_EN
   ,input  logic            stats_clr,
    output logic [7:0]      crc_err_cnt,
    output logic [7:0]      abort_cnt,
    output logic [7:0]      short_cnt,
    output logic [7:0]      ovf_cnt
`endif
);

    localparam int MEM_WORDS = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W:0] PTR_FCS   = (ADDR_W + 1)'(FCS_BYTES);
    localparam logic [ADDR_W:0] CNT_MIN   = (ADDR_W + 1)'(MIN_FRAME);
    localparam logic [ADDR_W:0] BUF_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]      mem_r [MEM_WORDS];

    logic            byte_ready_d_r;
    logic            frame_complete_d_r;
    logic            byte_ev_s;
    logic            done_ev_s;

    rx_state_e       state_r;
    rx_state_e       state_s;
    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] wr_ptr_s;
    logic [ADDR_W:0] commit_ptr_r;
    logic [ADDR_W:0] commit_ptr_s;
    logic [ADDR_W:0] rel_ptr_r;
    logic [ADDR_W:0] cnt_r;
    logic [ADDR_W:0] cnt_s;
    logic [ADDR_W:0] cnt_eff_s;
    logic [ADDR_W:0] wr_eff_s;
    logic [ADDR_W:0] occupancy_s;
    logic            buf_full_s;
    logic            byte_ovf_s;
    logic            mem_we_s;

    logic            push_s;
    rx_desc_t        push_desc_s;
    rx_desc_t        head_desc_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            pop_s;

    logic            drop_s;
    drop_cause_e     drop_cause_s;
    logic            rx_err_r;

    logic [ADDR_W:0]   rd_off_r;
    logic [ADDR_W-1:0] rd_addr_s;
    logic              rd_accept_s;
    logic [7:0]        rd_data_r;
    logic              rd_valid_r;

    assign byte_ev_s   = byte_ready & ~byte_ready_d_r;
    assign done_ev_s   = frame_complete & ~frame_complete_d_r;
    // Bytes held between the release point and the write pointer; equal to
    // the buffer depth means no free byte is left.
    assign occupancy_s = wr_ptr_r - rel_ptr_r;
    assign buf_full_s  = (occupancy_s == BUF_DEPTH);

    // Receive sequencer: next state, pointer updates, writes, push and drops.
    always_comb begin
        state_s      = state_r;
        wr_ptr_s     = wr_ptr_r;
        commit_ptr_s = commit_ptr_r;
        cnt_s        = cnt_r;
        cnt_eff_s    = cnt_r;
        wr_eff_s     = wr_ptr_r;
        byte_ovf_s   = 1'b0;
        mem_we_s     = 1'b0;
        push_s       = 1'b0;
        push_desc_s  = '0;
        drop_s       = 1'b0;
        drop_cause_s = SHORT;
        case (state_r)
            IDLE: begin
                if (!frame_abort && byte_ev_s && enable) begin
                    mem_we_s = 1'b1;
                    wr_ptr_s = wr_ptr_r + PTR_ONE;
                    cnt_s    = PTR_ONE;
                    state_s  = RECV;
                end else begin
                    state_s = IDLE;
                end
            end
            RECV: begin
                if (frame_abort) begin
                    wr_ptr_s     = commit_ptr_r;
                    drop_s       = 1'b1;
                    drop_cause_s = ABORT;
                    state_s      = IDLE;
                end else begin
                    // A byte arriving with the closing flag is taken first and
                    // counts toward the frame length.
                    if (byte_ev_s) begin
                        if (buf_full_s) begin
                            byte_ovf_s = 1'b1;
                        end else begin
                            mem_we_s  = 1'b1;
                            wr_eff_s  = wr_ptr_r + PTR_ONE;
                            cnt_eff_s = cnt_r + PTR_ONE;
                        end
                    end else begin
                        byte_ovf_s = 1'b0;
                    end
                    if (byte_ovf_s) begin
                        wr_ptr_s     = commit_ptr_r;
                        drop_s       = 1'b1;
                        drop_cause_s = OVF;
                        // If the flag closes the frame in the same cycle there
                        // is nothing left to discard.
                        state_s      = done_ev_s ? IDLE : DROP;
                    end else if (done_ev_s) begin
                        state_s = IDLE;
                        if (cnt_eff_s < CNT_MIN) begin
                            wr_ptr_s     = commit_ptr_r;
                            drop_s       = 1'b1;
                            drop_cause_s = SHORT;
                        end else if (!frame_valid) begin
                            wr_ptr_s     = commit_ptr_r;
                            drop_s       = 1'b1;
                            drop_cause_s = CRC;
                        end else if (fifo_full_s) begin
                            wr_ptr_s     = commit_ptr_r;
                            drop_s       = 1'b1;
                            drop_cause_s = OVF;
                        end else begin
                            // Commit point sits just before the FCS, so the
                            // next frame overwrites it.
                            push_s            = 1'b1;
                            push_desc_s.start = commit_ptr_r;
                            push_desc_s.len   = cnt_eff_s - PTR_FCS;
                            commit_ptr_s      = wr_eff_s - PTR_FCS;
                            wr_ptr_s          = wr_eff_s - PTR_FCS;
                        end
                    end else begin
                        wr_ptr_s = wr_eff_s;
                        cnt_s    = cnt_eff_s;
                    end
                end
            end
            DROP: begin
                if (frame_abort || done_ev_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Edge-detect delay flops, sequencer state, write-side pointers, rx_err.
    always_ff @(posedge netclk or negedge reset_n) begin
        if (!reset_n) begin
            byte_ready_d_r     <= 1'b0;
            frame_complete_d_r <= 1'b0;
            state_r            <= IDLE;
            wr_ptr_r           <= '0;
            commit_ptr_r       <= '0;
            cnt_r              <= '0;
            rx_err_r           <= 1'b0;
        end else begin
            byte_ready_d_r     <= byte_ready;
            frame_complete_d_r <= frame_complete;
            state_r            <= state_s;
            wr_ptr_r           <= wr_ptr_s;
            commit_ptr_r       <= commit_ptr_s;
            cnt_r              <= cnt_s;
            rx_err_r           <= drop_s;
        end
    end

    // Byte buffer write port.
    always_ff @(posedge netclk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= rx_byte;
        end
    end

    rx_desc_fifo #(
        .DEPTH_LOG2 (DESC_LOG2)
    ) u_desc_fifo (
        .netclk    (netclk),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_desc (push_desc_s),
        .pop       (pop_s),
        .head_desc (head_desc_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign pop_s       = desc_ack & ~fifo_empty_s;
    assign rd_accept_s = rd_req & ~fifo_empty_s & (rd_off_r < head_desc_s.len);
    assign rd_addr_s   = rel_ptr_r[ADDR_W-1:0] + rd_off_r[ADDR_W-1:0];

    // Host read port: registered byte read, read offset and release pointer.
    always_ff @(posedge netclk or negedge reset_n) begin
        if (!reset_n) begin
            rel_ptr_r  <= '0;
            rd_off_r   <= '0;
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_accept_s;
            if (rd_accept_s) begin
                rd_data_r <= mem_r[rd_addr_s];
            end
            if (pop_s) begin
                rel_ptr_r <= head_desc_s.start + head_desc_s.len;
                rd_off_r  <= '0;
            end else if (rd_accept_s) begin
                rd_off_r <= rd_off_r + PTR_ONE;
            end
        end
    end

    assign desc_valid = ~fifo_empty_s;
    assign desc_len   = head_desc_s.len;
    assign rd_data    = rd_data_r;
    assign rd_valid   = rd_valid_r;
    assign rx_err     = rx_err_r;

`ifdef RX_FRAME_STATS_EN
    logic [7:0] crc_err_cnt_r;
    logic [7:0] abort_cnt_r;
    logic [7:0] short_cnt_r;
    logic [7:0] ovf_cnt_r;

    // Saturating drop counters per cause; a clear beats a same-cycle count.
    always_ff @(posedge netclk or negedge reset_n) begin
        if (!reset_n) begin
            crc_err_cnt_r <= 8'h00;
            abort_cnt_r   <= 8'h00;
            short_cnt_r   <= 8'h00;
            ovf_cnt_r     <= 8'h00;
        end else if (stats_clr) begin
            crc_err_cnt_r <= 8'h00;
            abort_cnt_r   <= 8'h00;
            short_cnt_r   <= 8'h00;
            ovf_cnt_r     <= 8'h00;
        end else if (drop_s) begin
            case (drop_cause_s)
                CRC:     crc_err_cnt_r <= sat_inc8(crc_err_cnt_r);
                ABORT:   abort_cnt_r   <= sat_inc8(abort_cnt_r);
                SHORT:   short_cnt_r   <= sat_inc8(short_cnt_r);
                OVF:     ovf_cnt_r     <= sat_inc8(ovf_cnt_r);
                default: ovf_cnt_r     <= ovf_cnt_r;
            endcase
        end
    end

    assign crc_err_cnt = crc_err_cnt_r;
    assign abort_cnt   = abort_cnt_r;
    assign short_cnt   = short_cnt_r;
    assign ovf_cnt     = ovf_cnt_r;
`else
    // The drop cause only feeds the optional statistics counters.
    logic unused_cause_s;
    assign unused_cause_s = ^drop_cause_s;
`endif

endmodule

// File: tb/tb_rx_frame_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_buffer_ctrl
// Self-checking bench for rx_frame_buffer_ctrl (default build). A frame-level
// reference model (queue of committed payloads, occupancy in bytes) predicts
// drops, descriptors and read data for directed and randomized frames.
// ---------------------------------------------------------------------------
module tb_rx_frame_buffer_ctrl;

    logic        netclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        byte_ready = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        frame_complete = 1'b0;
    logic        frame_valid = 1'b0;
    logic        frame_abort = 1'b0;
    logic        desc_valid;
    logic [11:0] desc_len;
    logic        desc_ack = 1'b0;
    logic        rd_req = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rx_err;

    rx_frame_buffer_ctrl dut (
        .netclk         (netclk),
        .reset_n        (reset_n),
        .enable         (enable),
        .byte_ready     (byte_ready),
        .rx_byte        (rx_byte),
        .frame_complete (frame_complete),
        .frame_valid    (frame_valid),
        .frame_abort    (frame_abort),
        .desc_valid     (desc_valid),
        .desc_len       (desc_len),
        .desc_ack       (desc_ack),
        .rd_req         (rd_req),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rx_err         (rx_err)
    );

    always #5 netclk = ~netclk;

    localparam int BUF_BYTES = 2048;
    localparam int FIFO_SLOTS = 4;

    int         n_checks = 0;
    int         n_pass = 0;
    int         err_seen = 0;
    logic [7:0] frame_buf [2200];
    int         exp_len_q[$];
    logic [7:0] exp_data_q[$];
    int         rd_off_m = 0;

    // Count rx_err high cycles (sampled at the edge, before it updates).
    always @(posedge netclk) begin
        if (rx_err === 1'b1) err_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge netclk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge netclk);
        byte_ready = 1'b1;
        rx_byte = b;
        repeat (hold) @(negedge netclk);
        byte_ready = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
    endtask

    function automatic int occupancy();
        int s = 0;
        foreach (exp_len_q[i]) s += exp_len_q[i];
        return s;
    endfunction

    // Drive one frame from frame_buf and compare the outcome with the model.
    // abort_after > 0: abort after that many bytes instead of closing.
    task automatic run_frame(input int n, input bit valid, input int abort_after,
                             input int hold, input bit en, input bit mid_disable);
        int  err0;
        int  sent;
        bit  drop;
        bit  accept;
        err0 = err_seen;
        sent = (abort_after > 0) ? abort_after : n;
        enable = en;
        for (int i = 0; i < sent; i++) begin
            send_byte(frame_buf[i], hold);
            if (mid_disable) enable = 1'b0;
        end
        if (abort_after > 0) begin
            @(negedge netclk);
            frame_abort = 1'b1;
            @(negedge netclk);
            frame_abort = 1'b0;
        end else begin
            @(negedge netclk);
            frame_complete = 1'b1;
            frame_valid = valid;
            cyc(2);
            frame_complete = 1'b0;
            frame_valid = 1'b0;
        end
        cyc(3);
        enable = 1'b1;
        // Frame-level prediction.
        accept = 1'b0;
        if (!en) drop = 1'b0;
        else if (occupancy() + sent > BUF_BYTES) drop = 1'b1;
        else if (abort_after > 0) drop = 1'b1;
        else if (n < 4) drop = 1'b1;
        else if (!valid) drop = 1'b1;
        else if (exp_len_q.size() == FIFO_SLOTS) drop = 1'b1;
        else begin
            drop = 1'b0;
            accept = 1'b1;
        end
        if (accept) begin
            exp_len_q.push_back(n - 2);
            for (int i = 0; i < n - 2; i++) exp_data_q.push_back(frame_buf[i]);
        end
        check_eq("rx_err_pulses", 32'(err_seen - err0), 32'(drop));
        check_eq("desc_valid", 32'(desc_valid), 32'(exp_len_q.size() > 0));
        if (exp_len_q.size() > 0) check_eq("desc_len", 32'(desc_len), 32'(exp_len_q[0]));
    endtask

    task automatic read_one();
        bit ev;
        @(negedge netclk);
        rd_req = 1'b1;
        @(negedge netclk);
        rd_req = 1'b0;
        ev = (exp_len_q.size() > 0) && (rd_off_m < exp_len_q[0]);
        check_eq("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) begin
            check_eq("rd_data", 32'(rd_data), 32'(exp_data_q[rd_off_m]));
            rd_off_m++;
        end
    endtask

    task automatic do_ack();
        @(negedge netclk);
        desc_ack = 1'b1;
        @(negedge netclk);
        desc_ack = 1'b0;
        if (exp_len_q.size() > 0) begin
            for (int i = 0; i < exp_len_q[0]; i++) void'(exp_data_q.pop_front());
            void'(exp_len_q.pop_front());
            rd_off_m = 0;
        end
        check_eq("desc_valid_ack", 32'(desc_valid), 32'(exp_len_q.size() > 0));
    endtask

    // Read every remaining byte of each queued frame plus one rejected read.
    task automatic drain_all();
        int rem;
        while (exp_len_q.size() > 0) begin
            rem = exp_len_q[0] - rd_off_m;
            for (int i = 0; i <= rem; i++) read_one();
            do_ack();
        end
    endtask

    initial begin
        int n;
        int ab;
        // Reset state.
        cyc(3);
        check_eq("rst_desc_valid", 32'(desc_valid), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rx_err", 32'(rx_err), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'h00);
        reset_n = 1'b1;
        cyc(2);
        enable = 1'b1;

        // Good 6-byte frame 01..04 + FCS.
        for (int i = 0; i < 4; i++) frame_buf[i] = 8'(i + 1);
        frame_buf[4] = 8'($urandom);
        frame_buf[5] = 8'($urandom);
        run_frame(6, 1'b1, 0, 1, 1'b1, 1'b0);
        check_eq("t1_len4", 32'(desc_len), 32'd4);
        for (int i = 0; i < 5; i++) read_one();
        do_ack();

        // Same frame with bad FCS, then a good frame proves the rewind.
        run_frame(6, 1'b0, 0, 1, 1'b1, 1'b0);
        fill_random(7);
        run_frame(7, 1'b1, 0, 1, 1'b1, 1'b0);
        drain_all();

        // Abort after 3 bytes, then a 5-byte good frame.
        fill_random(3);
        run_frame(3, 1'b1, 3, 1, 1'b1, 1'b0);
        fill_random(5);
        run_frame(5, 1'b1, 0, 1, 1'b1, 1'b0);
        check_eq("t3_len3", 32'(desc_len), 32'd3);
        drain_all();

        // Short 3-byte frame with byte_ready held 3 cycles per byte.
        fill_random(3);
        run_frame(3, 1'b1, 0, 3, 1'b1, 1'b0);

        // Frame while disabled is ignored; disabling mid-frame does not matter.
        fill_random(6);
        run_frame(6, 1'b1, 0, 1, 1'b0, 1'b0);
        fill_random(6);
        run_frame(6, 1'b1, 0, 1, 1'b1, 1'b1);
        drain_all();

        // Fill the descriptor FIFO with large frames, 5th dropped; after one
        // release the next frame wraps across the end of the buffer.
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(482, 510);
            fill_random(n);
            run_frame(n, 1'b1, 0, 1, 1'b1, 1'b0);
        end
        fill_random(6);
        run_frame(6, 1'b1, 0, 1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) read_one();
        do_ack();
        fill_random(300);
        run_frame(300, 1'b1, 0, 1, 1'b1, 1'b0);
        drain_all();

        // Queued frame, then a 2100-byte flagless stream overflowing the buffer.
        fill_random(20);
        run_frame(20, 1'b1, 0, 1, 1'b1, 1'b0);
        fill_random(2100);
        run_frame(2100, 1'b1, 0, 1, 1'b1, 1'b0);
        fill_random(10);
        run_frame(10, 1'b1, 0, 1, 1'b1, 1'b0);
        drain_all();

        // Randomized frames with interleaved reads and releases.
        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(1, 40);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, n) : 0;
            fill_random(n);
            run_frame(n, ($urandom_range(0, 4) != 0), ab, $urandom_range(1, 3), 1'b1, 1'b0);
            repeat ($urandom_range(0, 8)) read_one();
            if ($urandom_range(0, 1) == 1) do_ack();
        end
        drain_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
